ec_slope_calc: RTL

//  Sequential modular slope unit; sits directly upstream of the point-add/double datapath and produces s.
//  Add:    s = (By - Ay) * (Bx - Ax)^-1 mod P.  Double: s = (3*Ax^2 + A) * (2*Ay)^-1 mod P.

---
 rtl/ec_slope_calc_if.sv | 27 ++
 rtl/ec_slope_calc.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ec_slope_calc_if.sv
// Request/response bundle for the modular slope unit.
// start is sampled only while the unit is idle; done is a one-cycle pulse with s/err valid.
interface ec_slope_calc_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             dbl;
  logic [WIDTH-1:0] Ax;
  logic [WIDTH-1:0] Ay;
  logic [WIDTH-1:0] Bx;
  logic [WIDTH-1:0] By;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] s;
  logic [2:0]       dbg_state;

  modport master (
    output start, dbl, Ax, Ay, Bx, By,
    input  busy, done, err, s, dbg_state
  );

  modport slave (
    input  start, dbl, Ax, Ay, Bx, By,
    output busy, done, err, s, dbg_state
  );
endinterface

// File: rtl/ec_slope_calc.sv
// Sequential modular slope: add s=(By-Ay)/(Bx-Ax), double s=(3Ax^2+A)/(2Ay) mod P.
// Doubling path (dbl input, SQR state, A coefficient) is present only with SLOPE_DBL_EN defined.
module ec_slope_calc #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] P     = 8'hFB,
  parameter logic [WIDTH-1:0] A     = '0
) (
  input  logic          Clk,
  input  logic          Reset,
  ec_slope_calc_if.slave bus
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH:0] PX   = {1'b0, P};

`ifdef SLOPE_DBL_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_SQR = 3'd2, S_INV = 3'd3, S_MUL = 3'd4, S_DONE = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_INV = 3'd3, S_MUL = 3'd4, S_DONE = 3'd5
  } state_t;
`endif

  function automatic logic [WIDTH-1:0] f_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] t;
    t = {1'b0, a} + {1'b0, b};
    if (t >= PX) t = t - PX;
    return t[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] f_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] t;
    if (a >= b) t = {1'b0, a} - {1'b0, b};
    else        t = {1'b0, a} + PX - {1'b0, b};
    return t[WIDTH-1:0];
  endfunction

  // x/2 mod P: odd x is made even by adding P, which needs the extra bit.
  function automatic logic [WIDTH-1:0] f_half(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] t;
    t = x[0] ? ({1'b0, x} + PX) : {1'b0, x};
    return t[WIDTH:1];
  endfunction

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_ax, r_ay, r_bx, r_by;
  logic [WIDTH-1:0] r_num, r_u, r_v, r_x1, r_x2;
  logic [WIDTH-1:0] r_acc, r_ma, r_mb;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_err;

  logic [WIDTH-1:0] w_den, w_num_add, w_acc2, w_acc_next;
  logic             w_range_err, w_load_err, w_mul_last, w_u_one, w_v_one;
  logic [WIDTH-1:0] w_u_nx, w_v_nx, w_x1_nx, w_x2_nx;

`ifdef SLOPE_DBL_EN
  logic             r_dbl;
  logic [WIDTH-1:0] w_num_dbl;
  assign w_range_err = r_dbl ? ((r_ax >= P) || (r_ay >= P))
                             : ((r_ax >= P) || (r_ay >= P) || (r_bx >= P) || (r_by >= P));
  assign w_den       = r_dbl ? f_add(r_ay, r_ay) : f_sub(r_bx, r_ax);
  assign w_num_dbl   = f_add(f_add(f_add(w_acc_next, w_acc_next), w_acc_next), A);
`else
  logic w_unused;
  assign w_unused    = ^{bus.dbl, A};
  assign w_range_err = (r_ax >= P) || (r_ay >= P) || (r_bx >= P) || (r_by >= P);
  assign w_den       = f_sub(r_bx, r_ax);
`endif

  assign w_num_add  = f_sub(r_by, r_ay);
  assign w_load_err = w_range_err || (w_den == '0);
  assign w_mul_last = (r_cnt == LAST);
  assign w_u_one    = (r_u == WIDTH'(1));
  assign w_v_one    = (r_v == WIDTH'(1));

  // Shared MSB-first shift-add multiplier: r_ma is the addend, r_mb shifts out its bits.
  assign w_acc2     = f_add(r_acc, r_acc);
  assign w_acc_next = r_mb[WIDTH-1] ? f_add(w_acc2, r_ma) : w_acc2;

  // One Euclid step; the odd/odd case subtracts and halves together (difference is even).
  always_comb begin
    w_u_nx  = r_u;
    w_v_nx  = r_v;
    w_x1_nx = r_x1;
    w_x2_nx = r_x2;
    if (!r_u[0]) begin
      w_u_nx  = r_u >> 1;
      w_x1_nx = f_half(r_x1);
    end else if (!r_v[0]) begin
      w_v_nx  = r_v >> 1;
      w_x2_nx = f_half(r_x2);
    end else if (r_u >= r_v) begin
      w_u_nx  = (r_u - r_v) >> 1;
      w_x1_nx = f_half(f_sub(r_x1, r_x2));
    end else begin
      w_v_nx  = (r_v - r_u) >> 1;
      w_x2_nx = f_half(f_sub(r_x2, r_x1));
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_LOAD;
      S_LOAD: begin
        if (w_load_err) w_next = S_DONE;
`ifdef SLOPE_DBL_EN
        else if (r_dbl) w_next = S_SQR;
`endif
        else            w_next = S_INV;
      end
`ifdef SLOPE_DBL_EN
      S_SQR:  if (w_mul_last) w_next = S_INV;
`endif
      S_INV:  if (w_u_one || w_v_one) w_next = S_MUL;
      S_MUL:  if (w_mul_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_ax <= '0; r_ay <= '0; r_bx <= '0; r_by <= '0;
      r_num <= '0; r_u <= '0; r_v <= '0; r_x1 <= '0; r_x2 <= '0;
      r_acc <= '0; r_ma <= '0; r_mb <= '0; r_cnt <= '0;
      r_s <= '0; r_err <= 1'b0;
`ifdef SLOPE_DBL_EN
      r_dbl <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_ax <= bus.Ax; r_ay <= bus.Ay; r_bx <= bus.Bx; r_by <= bus.By;
`ifdef SLOPE_DBL_EN
            r_dbl <= bus.dbl;
`endif
          end
        end
        S_LOAD: begin
          r_num <= w_num_add;
          r_u   <= w_den;
          r_v   <= P;
          r_x1  <= WIDTH'(1);
          r_x2  <= '0;
          r_acc <= '0;
          r_cnt <= '0;
          r_ma  <= r_ax;
          r_mb  <= r_ax;
          if (w_load_err) begin
            r_s   <= '0;
            r_err <= 1'b1;
          end
        end
`ifdef SLOPE_DBL_EN
        S_SQR: begin
          r_acc <= w_acc_next;
          r_mb  <= r_mb << 1;
          r_cnt <= r_cnt + 1'b1;
          if (w_mul_last) begin
            r_num <= w_num_dbl;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
`endif
        S_INV: begin
          if (w_u_one) begin
            r_ma <= r_num;
            r_mb <= r_x1;
          end else if (w_v_one) begin
            r_ma <= r_num;
            r_mb <= r_x2;
          end else begin
            r_u  <= w_u_nx;
            r_v  <= w_v_nx;
            r_x1 <= w_x1_nx;
            r_x2 <= w_x2_nx;
          end
        end
        S_MUL: begin
          r_acc <= w_acc_next;
          r_mb  <= r_mb << 1;
          r_cnt <= r_cnt + 1'b1;
          if (w_mul_last) begin
            r_s   <= w_acc_next;
            r_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.s         = r_s;
  assign bus.err       = r_err;
  assign bus.dbg_state = r_state;

endmodule
